// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: opcode values,
// sequencer state encodings, immediate-format codes and the datapath select
// encodings. The immediate generator reuses the opcode and imm_type codes.
package riscv_ctrl_pkg;

    // Major opcodes, IR bits [6:0]
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // Sequencer states; encodings are visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // ALU A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // ALU B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASS_B = 2'b11;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format implied by an opcode; unknown opcodes fall back to I
    function automatic logic [2:0] imm_type_for(input logic [6:0] op);
        case (op)
            OP_ITYPE, OP_LOAD, OP_JALR: imm_type_for = IMM_I;
            OP_STORE:                   imm_type_for = IMM_S;
            OP_BRANCH:                  imm_type_for = IMM_B;
            OP_LUI:                     imm_type_for = IMM_U;
            OP_JAL:                     imm_type_for = IMM_J;
            default:                    imm_type_for = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_instret_counter.sv
// instret_counter
// 32-bit retired-instruction counter, wraps at 2^32.
// Ports: clk, reset (async, active-high), inc_en (count this cycle),
//        count (current value).
module instret_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_en,
    output logic [31:0] count
);

    // Free-running wrap-around count of enabled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (inc_en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Sequencer for the multi-cycle RV32I datapath. Walks each instruction
// through fetch/decode/execute/memory/write-back and drives the datapath
// selects, write enables, ALU op and immediate format.
// Inputs : clk, reset (async, active-high), op_i (IR opcode),
//          mem_ready_i (memory access completes this cycle),
//          branch_taken_i (ALU compare result, used in BRANCH).
// Outputs: memory port controls (mem_req_o, mem_write_o, adr_src_o),
//          register enables (ir_write_o, pc_write_o, reg_write_o),
//          ALU/result selects, imm_type_o, state_o (debug), instret_o.
// Build option: ILLEGAL_TRAP_EN -- unknown opcodes enter an absorbing TRAP
//          state and the extra output illegal_o is present. Without it an
//          unknown opcode behaves as a retired NOP.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  result_src_o,
    output logic [2:0]  imm_type_o,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal_o,
`endif
    output logic [3:0]  state_o,
    output logic [31:0] instret_o
);

    state_t state;
    state_t next_state;
    logic   retire_en;

    // Next-state selection; memory states hold until the port reports ready
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op_i == OP_LOAD) begin
                    next_state = S_MEMREAD;
                end else if (op_i == OP_STORE) begin
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEMREAD:  next_state = mem_ready_i ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = mem_ready_i ? S_FETCH : S_MEMWRITE;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // An instruction retires when the sequencer returns to FETCH from
    // anywhere but FETCH itself (a stalled fetch) or TRAP
    assign retire_en = (next_state == S_FETCH) && (state != S_FETCH) &&
                       (state != S_TRAP);

    instret_counter u_instret (
        .clk    (clk),
        .reset  (reset),
        .inc_en (retire_en),
        .count  (instret_o)
    );

    assign state_o    = state;
    assign imm_type_o = imm_type_for(op_i);

    // Moore decode of the datapath controls; the only input-dependent terms
    // are the fetch-completion enables and the branch PC write
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = ALU_ADD;
        result_src_o = RES_ALUOUT;
`ifdef ILLEGAL_TRAP_EN
        illegal_o    = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                result_src_o = RES_MEM;
            end
            S_MEMWRITE: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_CMP;
                pc_write_o  = branch_taken_i;
            end
            S_JAL: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_FOUR;
                pc_write_o  = 1'b1;
                reg_write_o = 1'b1;
            end
            S_JALR: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_IMM;
                result_src_o = RES_ALU;
                pc_write_o   = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_LUI: begin
                alu_src_b_o  = SRC_B_IMM;
                alu_op_o     = ALU_PASS_B;
                result_src_o = RES_ALU;
                reg_write_o  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_o = 1'b1;
            end
`endif
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm
// Self-checking bench for multicycle_ctrl_fsm. Each instruction is modelled
// as the list of phases it must visit; memory phases repeat while ready is
// held low. Expected controls per phase come from the control table.
module tb_multicycle_ctrl_fsm;

    typedef int path_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op_i;
    logic        mem_ready_i;
    logic        branch_taken_i;
    logic        mem_req_o;
    logic        mem_write_o;
    logic        adr_src_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        reg_write_o;
    logic [1:0]  alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic [1:0]  result_src_o;
    logic [2:0]  imm_type_o;
    logic [3:0]  state_o;
    logic [31:0] instret_o;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int exp_instret = 0;

    multicycle_ctrl_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .op_i           (op_i),
        .mem_ready_i    (mem_ready_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_o      (mem_req_o),
        .mem_write_o    (mem_write_o),
        .adr_src_o      (adr_src_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .reg_write_o    (reg_write_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .result_src_o   (result_src_o),
        .imm_type_o     (imm_type_o),
`ifdef ILLEGAL_TRAP_EN
        .illegal_o      (illegal_o),
`endif
        .state_o        (state_o),
        .instret_o      (instret_o)
    );

    always #5 clk = ~clk;

    // Phases an opcode must visit, starting at FETCH
    function automatic path_t path_for(input logic [6:0] op);
        path_t q;
        q.push_back(0);
        q.push_back(1);
        case (op)
            7'h13: begin q.push_back(7);  q.push_back(8); end
            7'h33: begin q.push_back(6);  q.push_back(8); end
            7'h03: begin q.push_back(2);  q.push_back(3); q.push_back(4); end
            7'h23: begin q.push_back(2);  q.push_back(5); end
            7'h63: q.push_back(9);
            7'h6F: q.push_back(10);
            7'h67: q.push_back(11);
            7'h37: q.push_back(12);
            default: ;
        endcase
        return q;
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67: return 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h37:               return 3'd3;
            7'h6F:               return 3'd4;
            default:             return 3'd0;
        endcase
    endfunction

    // Expected {state, mem_req, mem_write, adr_src, ir_write, pc_write,
    // reg_write, alu_op, result_src, imm_type} for one cycle
    function automatic logic [16:0] exp_ctrl(input int ph, input logic rdy,
                                             input logic taken,
                                             input logic [6:0] op);
        logic       mreq, mw, adr, irw, pcw, rw;
        logic [1:0] aop, res;
        mreq = (ph == 0) || (ph == 3) || (ph == 5);
        mw   = (ph == 5);
        adr  = (ph == 3) || (ph == 5);
        irw  = (ph == 0) && rdy;
        pcw  = ((ph == 0) && rdy) || ((ph == 9) && taken) || (ph == 10) || (ph == 11);
        rw   = (ph == 4) || (ph == 8) || (ph == 10) || (ph == 11) || (ph == 12);
        aop  = (ph == 6 || ph == 7) ? 2'd2 : (ph == 9) ? 2'd1 : (ph == 12) ? 2'd3 : 2'd0;
        res  = (ph == 0 || ph == 11 || ph == 12) ? 2'd2 : (ph == 4) ? 2'd1 : 2'd0;
        return {4'(ph), mreq, mw, adr, irw, pcw, rw, aop, res, exp_imm(op)};
    endfunction

    // Drives one instruction to completion, checking every cycle
    task automatic run_instr(input logic [6:0] op, input logic taken,
                             input int fetch_stalls, input int mem_stalls,
                             output int cycles);
        path_t path;
        path   = path_for(op);
        cycles = 0;
        foreach (path[p]) begin
            int   stalls;
            logic is_mem;
            is_mem = (path[p] == 0) || (path[p] == 3) || (path[p] == 5);
            stalls = (path[p] == 0) ? fetch_stalls : (is_mem ? mem_stalls : 0);
            for (int c = 0; c <= stalls; c++) begin
                logic        rdy;
                logic [16:0] act, exp;
                @(negedge clk);
                op_i           = op;
                branch_taken_i = taken;
                rdy            = is_mem ? (c == stalls) : 1'($urandom_range(0, 1));
                mem_ready_i    = rdy;
                #1;
                cycles++;
                act = {state_o, mem_req_o, mem_write_o, adr_src_o, ir_write_o,
                       pc_write_o, reg_write_o, alu_op_o, result_src_o, imm_type_o};
                exp = exp_ctrl(path[p], rdy, taken, op);
                if (path[p] == 10) begin
                    act[4:3] = 2'b00;
                    exp[4:3] = 2'b00;
                end
                n_cmp++;
                if (act !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL ctrl op=%h phase=%0d got=%b expected=%b",
                             op, path[p], act, exp);
                end
                n_cmp++;
                if (instret_o !== 32'(exp_instret)) begin
                    n_fail++;
                    $display("[TB] FAIL instret op=%h phase=%0d got=%0d expected=%0d",
                             op, path[p], instret_o, exp_instret);
                end
            end
        end
`ifdef ILLEGAL_TRAP_EN
        if (path.size() > 2) exp_instret++;
`else
        exp_instret++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready_i = 1'b0; branch_taken_i = 1'b0; op_i = 7'h00;
        #3;
        n_cmp++;
        if (state_o !== 4'd0 || instret_o !== 32'd0 || mem_req_o !== 1'b1 ||
            ir_write_o !== 1'b0 || reg_write_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset state=%0d instret=%0d mem_req=%b ir_w=%b reg_w=%b expected 0,0,1,0,0",
                     state_o, instret_o, mem_req_o, ir_write_o, reg_write_o);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_instret = 0;
    endtask

    task automatic test_addi();
        int cyc;
        run_instr(7'h13, 1'b0, 0, 0, cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_fail++;
            $display("[TB] FAIL addi_cycles got=%0d expected=4", cyc);
        end
    endtask

    task automatic test_load_store();
        int cyc;
        run_instr(7'h03, 1'b0, 0, 2, cyc);
        n_cmp++;
        if (cyc !== 7) begin
            n_fail++;
            $display("[TB] FAIL lw_cycles got=%0d expected=7", cyc);
        end
        run_instr(7'h23, 1'b0, 1, 0, cyc);
        n_cmp++;
        if (cyc !== 5) begin
            n_fail++;
            $display("[TB] FAIL sw_cycles got=%0d expected=5", cyc);
        end
    endtask

    task automatic test_branch();
        int cyc;
        run_instr(7'h63, 1'b1, 0, 0, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_fail++;
            $display("[TB] FAIL beq_taken_cycles got=%0d expected=3", cyc);
        end
        run_instr(7'h63, 1'b0, 0, 0, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_fail++;
            $display("[TB] FAIL beq_not_taken_cycles got=%0d expected=3", cyc);
        end
    endtask

    task automatic test_jumps();
        int cyc;
        run_instr(7'h6F, 1'b0, 0, 0, cyc);
        run_instr(7'h67, 1'b0, 0, 0, cyc);
        run_instr(7'h37, 1'b0, 0, 0, cyc);
        run_instr(7'h33, 1'b0, 0, 0, cyc);
    endtask

    task automatic test_illegal();
        int cyc;
        run_instr(7'h7F, 1'b0, 0, 0, cyc);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready_i = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (state_o !== 4'd13 || illegal_o !== 1'b1 || mem_req_o !== 1'b0 ||
                pc_write_o !== 1'b0 || instret_o !== 32'(exp_instret)) begin
                n_fail++;
                $display("[TB] FAIL trap state=%0d illegal=%b mem_req=%b pc_w=%b instret=%0d expected 13,1,0,0,%0d",
                         state_o, illegal_o, mem_req_o, pc_write_o, instret_o, exp_instret);
            end
        end
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        mem_ready_i = 1'b0;
        exp_instret = 0;
`endif
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk);
        mem_ready_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state_o !== 4'd0 || instret_o !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid state=%0d instret=%0d expected 0,0", state_o, instret_o);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready_i = 1'b0;
        exp_instret = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b1 || state_o !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_release mem_req=%b state=%0d expected 1,0", mem_req_o, state_o);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        int cyc;
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F};
        for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), cyc);
`else
            run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), cyc);
`endif
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_random();
        test_reset_mid_fetch();
        test_addi();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
